trap_sequencer: RTL and testbench

- Drives the interrupt/return side of the machine-mode CSR block.
- Synchronises the external interrupt line, holds it as pending, and waits for an instruction boundary.
- When MIE is set, issues a one-cycle int_taken pulse and redirects fetch to mtvec.
- On a decoded mret, issues a one-cycle mret_exec pulse and redirects fetch to mepc.
- Sits between the control unit FSM and the CSR file; it stalls the core for the one cycle the CSR needs to commit its state.

---
 rtl/trap_sequencer.sv | 158 +++++++++++++++
 tb/tb_trap_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer
//
// Interrupt/return sequencer for the machine-mode CSR block. Synchronises the
// external interrupt line, holds it as pending until an instruction boundary,
// and then runs a one-cycle TRAP (redirect to mtvec) or RET (redirect to mepc)
// step. During that step it stalls the core so the CSR file can commit.
//
// Parameters:
//   SYNC_STAGES - flops in the intr_async synchroniser (2..4)
//   XLEN        - width of PC / mtvec / mepc / redirect_pc
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   intr_async   in   external interrupt request (asynchronous to clk)
//   instr_done   in   current instruction retires this cycle
//   mret_dec     in   retiring instruction is mret (qualified by instr_done)
//   mstatus_mie  in   global machine interrupt enable
//   mtvec        in   trap vector base (direct mode)
//   mepc         in   saved exception PC
//   int_taken    out  one-cycle pulse: CSR file saves PC, MIE->MPIE, clears MIE
//   mret_exec    out  one-cycle pulse: CSR file restores MPIE->MIE
//   stall        out  core holds PC and suppresses instr_done
//   pc_sel       out  00 sequential, 01 mepc, 10 mtvec
//   redirect_pc  out  redirect target, zero when pc_sel == 00
//   intr_pending out  pending interrupt status
//
// Build option:
//   TRAP_SEQ_LEVEL_EN - when defined, pending follows the synchronised line
//                       directly (level-sensitive). Default is edge-sensitive
//                       with a sticky pending flag.

module trap_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            intr_async,
    input  logic            instr_done,
    input  logic            mret_dec,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            int_taken,
    output logic            mret_exec,
    output logic            stall,
    output logic [1:0]      pc_sel,
    output logic [XLEN-1:0] redirect_pc,
    output logic            intr_pending
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_TRAP = 2'd1;
    localparam logic [1:0] ST_RET  = 2'd2;

    // Clears the two low bits: both targets are word-aligned.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   sync_out;
    logic                   pending;
    logic                   enter_trap;
    logic                   enter_ret;
    logic [1:0]             state;
    logic [1:0]             state_next;

    // Synchroniser stage boundary: intr_async -> sync_p[0] ... sync_out
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], intr_async};
        end
    end

    assign sync_out = sync_p[SYNC_STAGES-1];

    // Boundary decisions are only made in RUN; TRAP/RET are a blackout.
    assign enter_trap = (state == ST_RUN) && instr_done && pending && mstatus_mie;
    assign enter_ret  = (state == ST_RUN) && instr_done && mret_dec && !enter_trap;

`ifdef TRAP_SEQ_LEVEL_EN
    // Level mode: the source holds the line until serviced, so the
    // synchronised level is the request itself.
    assign pending = sync_out;
`else
    logic sync_prev;
    logic rise;

    assign rise = sync_out & ~sync_prev;

    // Edge stage boundary: previous sample and sticky pending flag.
    // A rise in the same cycle as trap entry keeps the flag set so the
    // new edge is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_prev <= 1'b0;
            pending   <= 1'b0;
        end else begin
            sync_prev <= sync_out;
            if (rise) begin
                pending <= 1'b1;
            end else if (enter_trap) begin
                pending <= 1'b0;
            end
        end
    end
`endif

    always_comb begin
        state_next = ST_RUN;
        if (enter_trap) begin
            state_next = ST_TRAP;
        end else if (enter_ret) begin
            state_next = ST_RET;
        end
    end

    // State stage boundary: TRAP and RET each last exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode the registered state only, so the pulses never see
    // a combinational path from the inputs.
    always_comb begin
        int_taken   = 1'b0;
        mret_exec   = 1'b0;
        stall       = 1'b0;
        pc_sel      = 2'b00;
        redirect_pc = '0;
        case (state)
            ST_TRAP: begin
                int_taken   = 1'b1;
                stall       = 1'b1;
                pc_sel      = 2'b10;
                redirect_pc = mtvec & ALIGN_MASK;
            end
            ST_RET: begin
                mret_exec   = 1'b1;
                stall       = 1'b1;
                pc_sel      = 2'b01;
                redirect_pc = mepc & ALIGN_MASK;
            end
            default: begin
                int_taken   = 1'b0;
            end
        endcase
    end

    assign intr_pending = pending;

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

    localparam int SS = 2;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          intr_async;
    logic          instr_done;
    logic          mret_dec;
    logic          mstatus_mie;
    logic [XL-1:0] mtvec;
    logic [XL-1:0] mepc;
    logic          int_taken;
    logic          mret_exec;
    logic          stall;
    logic [1:0]    pc_sel;
    logic [XL-1:0] redirect_pc;
    logic          intr_pending;

    always #5 clk = ~clk;

    trap_sequencer #(.SYNC_STAGES(SS), .XLEN(XL)) dut (
        .clk          (clk),
        .reset        (reset),
        .intr_async   (intr_async),
        .instr_done   (instr_done),
        .mret_dec     (mret_dec),
        .mstatus_mie  (mstatus_mie),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .int_taken    (int_taken),
        .mret_exec    (mret_exec),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .redirect_pc  (redirect_pc),
        .intr_pending (intr_pending)
    );

    typedef struct packed {
        logic          it;
        logic          me;
        logic          st;
        logic [1:0]    ps;
        logic [XL-1:0] rp;
        logic          pend;
    } out_t;

    typedef struct {
        logic intr;
        logic done;
        logic mret;
        logic mie;
        out_t exp;
    } vec_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    out_t idle0, idle1, trap0, trap1, ret0;
    vec_t tbl[26];

    function automatic out_t mk(input logic it, input logic me, input logic st,
                                input logic [1:0] ps, input logic [XL-1:0] rp,
                                input logic pend);
        out_t o;
        o.it = it; o.me = me; o.st = st; o.ps = ps; o.rp = rp; o.pend = pend;
        return o;
    endfunction

    function automatic vec_t mkv(input logic intr, input logic done, input logic mret,
                                 input logic mie, input out_t e);
        vec_t v;
        v.intr = intr; v.done = done; v.mret = mret; v.mie = mie; v.exp = e;
        return v;
    endfunction

    task automatic drive(input logic intr, input logic done, input logic mret,
                         input logic mie);
        intr_async  = intr;
        instr_done  = done;
        mret_dec    = mret;
        mstatus_mie = mie;
    endtask

    // Expected result for this cycle is queued with the stimulus and
    // retired once the DUT has responded to the clock edge.
    task automatic step(input string name, input out_t e);
        out_t got;
        out_t want;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want     = exp_q.pop_front();
        got.it   = int_taken;
        got.me   = mret_exec;
        got.st   = stall;
        got.ps   = pc_sel;
        got.rp   = redirect_pc;
        got.pend = intr_pending;
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got it=%b me=%b st=%b ps=%b rp=%h pend=%b, want it=%b me=%b st=%b ps=%b rp=%h pend=%b",
                     name, got.it, got.me, got.st, got.ps, got.rp, got.pend,
                     want.it, want.me, want.st, want.ps, want.rp, want.pend);
        end
    endtask

    initial begin
        idle0 = mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
        idle1 = mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
        trap0 = mk(1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0200, 1'b0);
        trap1 = mk(1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0200, 1'b1);
        ret0  = mk(1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_1004, 1'b0);

        // Interrupt take with unaligned mtvec
        tbl[0]  = mkv(1, 0, 0, 1, idle0);
        tbl[1]  = mkv(0, 0, 0, 1, idle0);
        tbl[2]  = mkv(0, 0, 0, 1, idle1);
        tbl[3]  = mkv(0, 0, 0, 1, idle1);
        tbl[4]  = mkv(0, 1, 0, 1, trap0);
        tbl[5]  = mkv(0, 0, 0, 1, idle0);
        tbl[6]  = mkv(0, 0, 0, 1, idle0);
        // mret, and mret_dec without instr_done
        tbl[7]  = mkv(0, 1, 1, 1, ret0);
        tbl[8]  = mkv(0, 0, 0, 1, idle0);
        tbl[9]  = mkv(0, 0, 1, 1, idle0);
        tbl[10] = mkv(0, 0, 0, 1, idle0);
        // Masked interrupt held across boundaries, taken once MIE rises
        tbl[11] = mkv(1, 0, 0, 0, idle0);
        tbl[12] = mkv(0, 0, 0, 0, idle0);
        tbl[13] = mkv(0, 1, 0, 0, idle1);
        tbl[14] = mkv(0, 1, 0, 0, idle1);
        tbl[15] = mkv(0, 1, 0, 0, idle1);
        tbl[16] = mkv(0, 1, 0, 0, idle1);
        tbl[17] = mkv(0, 1, 0, 0, idle1);
        tbl[18] = mkv(0, 0, 0, 1, idle1);
        tbl[19] = mkv(0, 1, 0, 1, trap0);
        tbl[20] = mkv(0, 0, 0, 1, idle0);
        // Interrupt pre-empts a coincident mret
        tbl[21] = mkv(1, 0, 0, 1, idle0);
        tbl[22] = mkv(0, 0, 0, 1, idle0);
        tbl[23] = mkv(0, 0, 0, 1, idle1);
        tbl[24] = mkv(0, 1, 1, 1, trap0);
        tbl[25] = mkv(0, 0, 0, 1, idle0);

        mtvec = 32'h0000_0203;
        mepc  = 32'h0000_1004;
        reset = 1'b1;
        drive(1, 0, 0, 0);

        // Reset with the line held high
        for (int i = 0; i < 3; i++) step($sformatf("reset%0d", i), idle0);
        reset = 1'b0;
        step("post_reset1", idle0);
        step("post_reset2", idle0);
        step("post_reset3_pending", idle1);
        drive(0, 1, 0, 1);
        step("post_reset_take", trap0);
        drive(0, 0, 0, 1);
        step("post_reset_idle1", idle0);
        step("post_reset_idle2", idle0);

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].intr, tbl[i].done, tbl[i].mret, tbl[i].mie);
            step($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Blackout and set-wins: new edge lands as the trap is entered,
        // and instr_done during TRAP is ignored.
        drive(1, 0, 0, 0); step("blk0", idle0);
        drive(0, 0, 0, 0); step("blk1", idle0);
        drive(0, 0, 0, 0); step("blk2", idle1);
        drive(1, 0, 0, 0); step("blk3", idle1);
        drive(0, 0, 0, 0); step("blk4", idle1);
        drive(0, 1, 0, 1); step("blk5_trap_set_wins", trap1);
        drive(0, 1, 0, 1); step("blk6_no_second_take", idle1);
        drive(0, 0, 0, 0); step("blk7", idle1);
        drive(0, 1, 0, 1); step("blk8_take_merged", trap0);
        drive(0, 0, 0, 0); step("blk9", idle0);

        // Reset during RET aborts the sequence
        drive(0, 1, 1, 1); step("rst_ret_enter", ret0);
        reset = 1'b1; drive(0, 0, 0, 1); step("rst_ret_abort", idle0);
        reset = 1'b0; step("rst_ret_after", idle0);

        // Reset during TRAP aborts the sequence
        drive(1, 0, 0, 0); step("rst_trap0", idle0);
        drive(0, 0, 0, 0); step("rst_trap1", idle0);
        drive(0, 0, 0, 0); step("rst_trap2", idle1);
        drive(0, 1, 0, 1); step("rst_trap_enter", trap0);
        reset = 1'b1; drive(0, 0, 0, 1); step("rst_trap_abort", idle0);
        reset = 1'b0; step("rst_trap_after", idle0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
